// File: rtl/piano_pkg.sv
// Shared types and constants for the piano-tiles game datapath.
// Lane order everywhere is A, S, D, F (lane 0 .. lane 3).
package piano_pkg;

  localparam int NUM_LANES = 4;
  localparam int Y_W       = 10;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_F     = 8'h09;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } game_state_t;

  // Right-shifting Galois step with taps 8'hB8; a nonzero state never reaches zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR used to pick spawn lanes.
module lfsr8
  import piano_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic [7:0] value
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) value <= SEED;
    else          value <= lfsr_next(value);
  end

endmodule

// File: rtl/tile_scheduler.sv
// Game sequencer for the four-lane piano-tiles datapath: owns tile positions,
// spawns, advances and retires tiles, ramps speed and runs IDLE/PLAY/OVER.
module tile_scheduler
  import piano_pkg::*;
#(
  parameter logic [Y_W-1:0] SPAWN_Y        = 10'd0,
  parameter logic [Y_W-1:0] MISS_Y         = 10'd400,
  parameter int             SPAWN_GAP      = 40,
  parameter logic [3:0]     INIT_SPEED     = 4'd2,
  parameter logic [3:0]     MAX_SPEED      = 4'd12,
  parameter int             SPEEDUP_SPAWNS = 16,
  parameter int             MAX_MISSES     = 3,
  parameter logic [7:0]     LFSR_SEED      = 8'hA5
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic [7:0]  keycode,
  input  logic [3:0]  hit,
  output logic [39:0] tile_y,
  output logic [3:0]  tile_valid,
  output logic [3:0]  speed,
  output logic [3:0]  miss_count,
  output logic [1:0]  game_state,
  output logic        spawn_pulse,
  output logic        miss_pulse
);

  localparam int GAP_W = 16;
  localparam int SPN_W = 8;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SPAWN_GAP);
  localparam logic [SPN_W-1:0] SPN_LIMIT  = SPN_W'(SPEEDUP_SPAWNS);
  localparam logic [4:0]       MISS_LIMIT = 5'(MAX_MISSES);

  game_state_t state_q, state_d;

  logic [NUM_LANES-1:0][Y_W-1:0] y_q, y_d;
  logic [NUM_LANES-1:0]          valid_q, valid_d;
  logic [3:0]                    speed_q, speed_d;
  logic [3:0]                    miss_q, miss_d;
  logic [GAP_W-1:0]              gap_q, gap_d;
  logic [SPN_W-1:0]              spawn_cnt_q, spawn_cnt_d;
  logic                          spawn_pulse_d, miss_pulse_d;
  logic                          space_q;
  logic                          start;
  logic [7:0]                    lfsr_value;
  logic                          unused_lfsr_bits;

  logic [Y_W:0]  adv;
  logic [2:0]    lost;
  logic [4:0]    miss_sum;
  logic [1:0]    lane;
  logic          found;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .value   (lfsr_value)
  );

  assign unused_lfsr_bits = ^lfsr_value[7:2];

  // Holding space only counts once: start fires on the first cycle it appears.
  assign start = (keycode == KEY_SPACE) && !space_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Per-lane retirement happens before the spawn search so a lane freed by a
  // hit or miss on this tick is already eligible for the new tile.
  always_comb begin
    state_d       = state_q;
    y_d           = y_q;
    valid_d       = valid_q;
    speed_d       = speed_q;
    miss_d        = miss_q;
    gap_d         = gap_q;
    spawn_cnt_d   = spawn_cnt_q;
    spawn_pulse_d = 1'b0;
    miss_pulse_d  = 1'b0;
    adv           = '0;
    lost          = '0;
    miss_sum      = '0;
    lane          = '0;
    found         = 1'b0;

    if (start) begin
      state_d     = PLAY;
      valid_d     = '0;
      y_d         = {NUM_LANES{SPAWN_Y}};
      speed_d     = INIT_SPEED;
      miss_d      = '0;
      spawn_cnt_d = '0;
      gap_d       = GAP_W'(1);
    end else if (state_q == PLAY) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (hit[i] && valid_q[i]) begin
          valid_d[i] = 1'b0;
        end else if (frame_tick && valid_q[i]) begin
          adv = {1'b0, y_q[i]} + {7'd0, speed_q};
          if (adv > {1'b0, MISS_Y}) begin
            valid_d[i] = 1'b0;
            lost       = lost + 3'd1;
          end else begin
            y_d[i] = adv[Y_W-1:0];
          end
        end
      end

      if (frame_tick) begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d = GAP_RELOAD;
          for (int k = 0; k < NUM_LANES; k++) begin
            lane = lfsr_value[1:0] + 2'(k);
            if (!found && !valid_d[lane]) begin
              found        = 1'b1;
              valid_d[lane] = 1'b1;
              y_d[lane]     = SPAWN_Y;
            end
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      if (found) begin
        spawn_pulse_d = 1'b1;
        if (spawn_cnt_q + SPN_W'(1) == SPN_LIMIT) begin
          spawn_cnt_d = '0;
          if (speed_q < MAX_SPEED) speed_d = speed_q + 4'd1;
        end else begin
          spawn_cnt_d = spawn_cnt_q + SPN_W'(1);
        end
      end

      if (lost != 3'd0) begin
        miss_pulse_d = 1'b1;
        miss_sum     = {1'b0, miss_q} + {2'b0, lost};
        miss_d       = (miss_sum > 5'd15) ? 4'd15 : miss_sum[3:0];
        if (miss_sum >= MISS_LIMIT) state_d = OVER;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      y_q         <= {NUM_LANES{SPAWN_Y}};
      valid_q     <= '0;
      speed_q     <= INIT_SPEED;
      miss_q      <= '0;
      gap_q       <= '0;
      spawn_cnt_q <= '0;
      spawn_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      space_q     <= 1'b0;
    end else begin
      y_q         <= y_d;
      valid_q     <= valid_d;
      speed_q     <= speed_d;
      miss_q      <= miss_d;
      gap_q       <= gap_d;
      spawn_cnt_q <= spawn_cnt_d;
      spawn_pulse <= spawn_pulse_d;
      miss_pulse  <= miss_pulse_d;
      space_q     <= (keycode == KEY_SPACE);
    end
  end

  assign tile_y     = y_q;
  assign tile_valid = valid_q;
  assign speed      = speed_q;
  assign miss_count = miss_q;
  assign game_state = state_q;

endmodule
